// File: rtl/divisorclock_multi_if.sv
// divisorclock_multi_if: control/status bundle for the multi-channel divider.
//   En          per-channel enable
//   Load        one-cycle shadow write strobe
//   Load_ch     channel addressed by Load (writes to channels >= N are dropped)
//   Load_period new period in Clk_in cycles
//   Load_high   new high time in Clk_in cycles
//   Clk_out     registered divided clocks
//   Tick        one-cycle pulse per channel on each period wrap
//   Pending     channel holds a shadow value not yet applied
// master drives the control side, slave is the divider.
interface divisorclock_multi_if #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int CHW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   En;
  logic           Load;
  logic [CHW-1:0] Load_ch;
  logic [W-1:0]   Load_period;
  logic [W-1:0]   Load_high;
  logic [N-1:0]   Clk_out;
  logic [N-1:0]   Tick;
  logic [N-1:0]   Pending;

  modport master (
    output En, Load, Load_ch, Load_period, Load_high,
    input  Clk_out, Tick, Pending
  );

  modport slave (
    input  En, Load, Load_ch, Load_period, Load_high,
    output Clk_out, Tick, Pending
  );
endinterface

// File: rtl/divisorclock_multi.sv
// divisorclock_multi: N independent programmable clock dividers.
// Each channel counts 0..P-1, drives Clk_out high for the first min(H,P)
// cycles of every period and pulses Tick on the wrap edge. New P/H values
// land in a shadow register and are applied only at a wrap or while the
// channel is idle, so a running output never glitches mid-period.
// Ports:
//   Clk_in  system clock, rising edge
//   Rst     asynchronous active-high reset
//   bus     divisorclock_multi_if.slave (enables, load bus, outputs)

// One divider channel.
module divisorclock_ch #(
  parameter int             W          = 32,
  parameter logic [W-1:0]   DEF_PERIOD = W'(50000000),
  parameter logic [W-1:0]   DEF_HIGH   = W'(25000000)
) (
  input  logic         Clk_in,
  input  logic         Rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_period,
  input  logic [W-1:0] wr_high,
  output logic         clk_out,
  output logic         tick,
  output logic         pending
);
  logic [W-1:0] cnt, act_p, act_h, sh_p, sh_h;
  logic [W-1:0] cnt_nx, h_nx;
  logic         running, wrap, apply;

  always_comb begin
    running = en && (act_p != '0);
    wrap    = running && (cnt == act_p - W'(1));
    // Apply only where the count is back at zero: a wrap, or any idle edge.
    apply   = pending && (!running || wrap);
    h_nx    = apply ? sh_h : act_h;
    cnt_nx  = (running && !wrap) ? cnt + W'(1) : '0;
  end

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      cnt     <= '0;
      act_p   <= DEF_PERIOD;
      act_h   <= DEF_HIGH;
      sh_p    <= DEF_PERIOD;
      sh_h    <= DEF_HIGH;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      tick    <= wrap;
      clk_out <= running && (cnt_nx < h_nx);
      if (apply) begin
        act_p <= sh_p;
        act_h <= sh_h;
      end
      // A write coinciding with an apply still lands: the apply took the
      // old shadow contents, the new ones wait for the next boundary.
      if (wr) begin
        sh_p    <= wr_period;
        sh_h    <= wr_high;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

module divisorclock_multi #(
  parameter int           N          = 4,
  parameter int           W          = 32,
  parameter logic [W-1:0] DEF_PERIOD = W'(50000000),
  parameter logic [W-1:0] DEF_HIGH   = W'(25000000)
) (
  input  logic                  Clk_in,
  input  logic                  Rst,
  divisorclock_multi_if.slave   bus
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] clk_v, tick_v, pend_v;

  // Decode compares against in-range indices only, so Load_ch >= N
  // matches no channel and the write is dropped.
  for (genvar i = 0; i < N; i++) begin : g_ch
    divisorclock_ch #(
      .W          (W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .Clk_in    (Clk_in),
      .Rst       (Rst),
      .en        (bus.En[i]),
      .wr        (bus.Load && (bus.Load_ch == CHW'(i))),
      .wr_period (bus.Load_period),
      .wr_high   (bus.Load_high),
      .clk_out   (clk_v[i]),
      .tick      (tick_v[i]),
      .pending   (pend_v[i])
    );
  end

  assign bus.Clk_out = clk_v;
  assign bus.Tick    = tick_v;
  assign bus.Pending = pend_v;
endmodule

// File: tb/tb_divisorclock_multi.sv
// Directed bench for divisorclock_multi. Stimulus pushes hand-computed
// expectations into a queue after each edge; a monitor on the falling
// edge pops and compares them against the selected DUT instance.
module tb_divisorclock_multi;
  logic Clk_in = 1'b0;
  logic Rst;
  always #5 Clk_in = ~Clk_in;

  divisorclock_multi_if #(.N(4), .W(8)) if4 ();
  divisorclock_multi_if #(.N(3), .W(8)) if3 ();

  divisorclock_multi #(.N(4), .W(8), .DEF_PERIOD(8'd4), .DEF_HIGH(8'd2)) u_dut4 (
    .Clk_in (Clk_in),
    .Rst    (Rst),
    .bus    (if4.slave)
  );

  divisorclock_multi #(.N(3), .W(8), .DEF_PERIOD(8'd4), .DEF_HIGH(8'd2)) u_dut3 (
    .Clk_in (Clk_in),
    .Rst    (Rst),
    .bus    (if3.slave)
  );

  typedef struct {
    int         dut;
    logic [3:0] m;
    logic [3:0] c;
    logic [3:0] t;
    logic [3:0] p;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor
  exp_t       e;
  logic [3:0] a_c, a_t, a_p;
  always @(negedge Clk_in) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 4) begin
        a_c = if4.Clk_out; a_t = if4.Tick; a_p = if4.Pending;
      end else begin
        a_c = {1'b0, if3.Clk_out}; a_t = {1'b0, if3.Tick}; a_p = {1'b0, if3.Pending};
      end
      n_tests++;
      if ((((a_c ^ e.c) | (a_t ^ e.t) | (a_p ^ e.p)) & e.m) != 4'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: got clk=%b tick=%b pend=%b, want clk=%b tick=%b pend=%b (mask %b)",
                 e.nm, e.dut, a_c, a_t, a_p, e.c, e.t, e.p, e.m);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic chk(input int d, input logic [3:0] m, input logic [3:0] c,
                     input logic [3:0] t, input logic [3:0] p, input string nm);
    exp_t x;
    x = '{d, m, c, t, p, nm};
    q.push_back(x);
  endtask

  task automatic ld4(input int ch, input int p, input int h);
    if4.Load        = 1'b1;
    if4.Load_ch     = 2'(ch);
    if4.Load_period = 8'(p);
    if4.Load_high   = 8'(h);
  endtask

  int pc[8] = '{1, 0, 0, 1, 1, 0, 0, 1};
  int pt[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int c6[6] = '{1, 1, 0, 0, 0, 1};
  int t6[6] = '{0, 0, 0, 0, 0, 1};
  int c3[6] = '{0, 0, 1, 0, 0, 1};
  int hv[3] = '{0, 5, 9};

  initial begin
    Rst = 1'b1;
    if4.En = '0; if4.Load = 1'b0; if4.Load_ch = '0; if4.Load_period = '0; if4.Load_high = '0;
    if3.En = '0; if3.Load = 1'b0; if3.Load_ch = '0; if3.Load_period = '0; if3.Load_high = '0;

    // Reset state and default P=4,H=2 on ch0
    cyc(); cyc();
    chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "rst_init4");
    chk(3, 4'h7, 4'h0, 4'h0, 4'h0, "rst_init3");
    Rst = 1'b0;
    if4.En = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      cyc(); chk(4, 4'hF, 4'(pc[k]), 4'(pt[k]), 4'h0, "ch0_default");
    end
    cyc();                                   // cnt=1, Clk_out[0]=1
    Rst = 1'b1; #1;
    chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "rst_async");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "rst_hold");
    Rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); chk(4, 4'hF, 4'(pc[k]), 4'(pt[k]), 4'h0, "ch0_restart");
    end

    // Shadow apply at wrap: load P=6,H=3 at cnt=1
    cyc(); chk(4, 4'hF, 4'h1, 4'h0, 4'h0, "pre_load");
    ld4(0, 6, 3);
    cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h0, 4'h0, 4'h1, "shadow_pend");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h1, "shadow_hold");
    cyc(); chk(4, 4'hF, 4'h1, 4'h1, 4'h0, "apply_wrap");
    for (int k = 0; k < 6; k++) begin
      cyc(); chk(4, 4'hF, 4'(c6[k]), 4'(t6[k]), 4'h0, "p6h3");
    end

    // Load coincident with wrap
    if4.En = 4'b0000; ld4(0, 4, 2);
    cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h0, 4'h0, 4'h1, "idle_wr");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "idle_apply");
    if4.En = 4'b0001; ld4(0, 8, 4);
    cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h1, 4'h0, 4'h1, "run_wr");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h1, "run_cnt2");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h1, "run_cnt3");
    ld4(0, 2, 1);
    cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h1, 4'h1, 4'h1, "wrap_coinc");
    for (int k = 1; k < 8; k++) begin
      cyc(); chk(4, 4'hF, (k < 4) ? 4'h1 : 4'h0, 4'h0, 4'h1, "p8h4");
    end
    cyc(); chk(4, 4'hF, 4'h1, 4'h1, 4'h0, "p2_apply");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "p2h1_a");
    cyc(); chk(4, 4'hF, 4'h1, 4'h1, 4'h0, "p2h1_b");

    // Duty extremes on ch1, applied while idle
    for (int i = 0; i < 3; i++) begin
      if4.En = 4'b0000; ld4(1, 5, hv[i]);
      cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h0, 4'h0, 4'h2, "duty_wr");
      cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "duty_apply");
      if4.En = 4'b0010;
      for (int k = 1; k <= 10; k++) begin
        cyc(); chk(4, 4'hF, (hv[i] != 0) ? 4'h2 : 4'h0, (k % 5 == 0) ? 4'h2 : 4'h0, 4'h0, "duty");
      end
    end

    // P=0 keeps ch2 idle; reload to P=3,H=1
    if4.En = 4'b0000; ld4(2, 0, 2);
    cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h0, 4'h0, 4'h4, "p0_wr");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "p0_apply");
    if4.En = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "p0_idle");
    end
    ld4(2, 3, 1);
    cyc(); if4.Load = 1'b0; chk(4, 4'hF, 4'h0, 4'h0, 4'h4, "p3_wr");
    cyc(); chk(4, 4'hF, 4'h0, 4'h0, 4'h0, "p3_apply");
    for (int k = 0; k < 6; k++) begin
      cyc(); chk(4, 4'hF, 4'(c3[k]) << 2, 4'(c3[k]) << 2, 4'h0, "p3h1");
    end

    // N=3: out-of-range load dropped, En[1] toggling leaves ch0/ch2 alone
    if4.En = 4'b0000;
    if3.Load = 1'b1; if3.Load_ch = 2'd3; if3.Load_period = 8'd2; if3.Load_high = 8'd1;
    cyc(); if3.Load = 1'b0; chk(3, 4'h7, 4'h0, 4'h0, 4'h0, "oor_load");
    if3.En = 3'b101;
    for (int k = 0; k < 8; k++) begin
      if3.En[1] = ~if3.En[1];
      cyc(); chk(3, 4'h5, 4'(pc[k]) * 4'h5, 4'(pt[k]) * 4'h5, 4'h0, "indep");
    end

    cyc();
    @(negedge Clk_in); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/divisorclock_multi.md
Name: divisorclock_multi

Overview:
Parametrised, multi-channel programmable clock divider; next generation of the single-channel toggle divider. Each of N channels produces a registered divided clock with programmable period and high time (duty), a one-cycle wrap tick, and a per-channel enable. New settings go into shadow registers and are applied glitch-free at a period boundary. Sits between the board clock and slow consumers (display multiplexing, debouncers, LED blinkers).

Parameters:
N, 4, number of independent divider channels (1..16)
W, 32, width of period/high-time values and per-channel counter
DEF_PERIOD, 50000000, reset value of every channel's active and shadow period
DEF_HIGH, 25000000, reset value of every channel's active and shadow high time
CHW (localparam), max(1, clog2(N)), width of the channel-select field

Ports:
Clk_in  input  1  system clock; all state changes on its rising edge
Rst  input  1  asynchronous, active-high reset
En  input  N  per-channel enable, bit i controls channel i
Load  input  1  one-cycle write strobe for the shadow registers
Load_ch  input  CHW  channel addressed by Load
Load_period  input  W  new period P in Clk_in cycles
Load_high  input  W  new high time H in Clk_in cycles
Clk_out  output  N  registered divided clocks
Tick  output  N  one-cycle pulse per channel on each period wrap
Pending  output  N  bit i high while channel i holds an unapplied shadow value

Behaviour:
- Reset (async, Rst=1): all cnt=0; active P/H and shadow P/H = DEF_PERIOD/DEF_HIGH; Clk_out=0, Tick=0, Pending=0. This state holds while Rst=1. Rst asserted mid-period aborts immediately. Any pending load is discarded.
- A channel is "running" when En[i]=1 and its active P≠0. Otherwise it is "idle".
- Idle channel on each edge:
  - cnt←0, Clk_out[i]←0, Tick[i]←0.
  - If Pending[i]=1, active←shadow and Pending[i]←0.
- Running channel on each edge:
  - Wrap: if cnt==P−1, then cnt←0 and Tick[i]←1. If Pending[i]=1, active←shadow and Pending[i]←0.
  - Otherwise: cnt←cnt+1, Tick[i]←0.
  - Clk_out[i]←(cnt_next < H_next), where H_next is the active H after this edge.
  - Result: period P cycles, high for the first min(H,P) cycles of each period.
- Duty edge cases:
  - H=0: Clk_out constant 0.
  - H≥P: Clk_out constant 1.
  - P=1: cnt stays 0, Tick=1 every cycle, Clk_out=(H≥1).
- Enable rise: counting resumes from cnt=0. The first edge moves cnt to 1 (or wraps if P=1), so the first Tick occurs P edges after enable.
- Load (Load=1, Load_ch<N):
  - Shadow[Load_ch]←{Load_period, Load_high}; Pending[Load_ch]←1.
  - A write to an out-of-range Load_ch (≥N) is ignored.
- Load in the same cycle as a wrap or idle-apply on that channel:
  - The apply uses the shadow contents before the write.
  - The new write lands in shadow and Pending stays 1, so it applies at the next wrap or idle edge.
- Back-to-back loads to the same channel before a wrap: the last write wins.
- Arithmetic: cnt compare and increment in W bits; cnt never exceeds P−1. A reload to P smaller than the current cnt cannot occur, because apply happens only at cnt=0.
- Channels are fully independent, with no shared state except the load bus.

Test Plan:
- Reset: assert Rst mid-count with N=4, W=8, DEF_PERIOD=4, DEF_HIGH=2 -> Clk_out=0, Tick=0, Pending=0 immediately (async); after release with En=4'b0001, ch0 Clk_out over edges 1..8 = 1,0,0,1,1,0,0,1, and Tick[0]=1 at edges 4 and 8 only.
- Duty extremes: load ch1 P=5,H=0 / H=5 / H=9, with ch1 disabled so each applies at once -> Clk_out[1] constant 0 / 1 / 1; Tick[1] every 5 cycles in all three cases.
- Shadow apply: ch0 running P=4,H=2; at cnt=1 load P=6,H=3 -> Pending[0]=1 until the wrap edge, first new period starts at that wrap, then Clk_out is 3 high / 3 low, Tick every 6.
- Load coincident with wrap: ch0 P=4 with Pending=1 (shadow P=8); at cnt=3 load P=2 -> the wrap applies P=8, Pending stays 1, and P=2 applies 8 edges later.
- Idle/P=0: load P=0 on ch2 with En[2]=1 -> Clk_out[2]=0 and Tick[2]=0 permanently; a later load P=3,H=1 applies on the next edge, with the first Tick 3 edges after that.
- Out-of-range / independence: N=3, Load_ch=3 -> no shadow changes, Pending=0; toggling En[1] does not disturb ch0 or ch2 waveforms.
